// File: rtl/adc_scanner.sv
// Round-robin scanner for an ADS1115-class I2C ADC: configures each channel for a
// single-shot conversion, polls for completion, reads the result and publishes it.
module adc_scanner #(
    parameter logic [6:0]  ADDRESS      = 7'h48,
    parameter int          NUM_CHANNELS = 4,
    parameter logic [11:0] CH_MUX       = 12'b111_110_101_100,
    parameter logic [2:0]  PGA          = 3'b001,
    parameter logic [2:0]  DATA_RATE    = 3'b111,
    parameter logic [7:0]  POLL_DELAY   = 8'd255,
    parameter logic [7:0]  MAX_POLLS    = 8'd16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        continuous_i,
    output logic        busy_o,
    output logic        sample_valid_o,
    output logic [1:0]  sample_channel_o,
    output logic [15:0] sample_data_o,
    output logic        scan_done_o,
    output logic        timeout_o,
    output logic [1:0]  i2c_instruction_o,
    output logic        i2c_enable_o,
    output logic [7:0]  i2c_byte_to_send_o,
    input  logic [7:0]  i2c_byte_received_i,
    input  logic        i2c_complete_i
);

    localparam logic [1:0] INSTR_START = 2'd0;
    localparam logic [1:0] INSTR_STOP  = 2'd1;
    localparam logic [1:0] INSTR_READ  = 2'd2;
    localparam logic [1:0] INSTR_WRITE = 2'd3;
    localparam logic [1:0] LAST_CH     = 2'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_DELAY, S_POLL, S_SET_PTR, S_READ, S_PUBLISH, S_NEXT
    } state_t;

    typedef enum logic [1:0] {
        HS_WAIT_LOW, HS_WAIT_HIGH, HS_GAP
    } hs_t;

    state_t      state, state_next;
    hs_t         hs;
    logic [2:0]  step;
    logic [2:0]  last_step;
    logic        is_i2c;
    logic [7:0]  delay_cnt;
    logic [7:0]  poll_count;
    logic [1:0]  ch;
    logic        ready;
    logic [15:0] rd_data;
    logic [2:0]  mux_code;
    logic        byte_done;
    logic        frame_done;
    logic        poll_exhausted;

    always_comb begin
        case (ch)
            2'd0:    mux_code = CH_MUX[2:0];
            2'd1:    mux_code = CH_MUX[5:3];
            2'd2:    mux_code = CH_MUX[8:6];
            default: mux_code = CH_MUX[11:9];
        endcase
    end

    // Every frame opens with START (step 0) and closes with STOP (last_step).
    always_comb begin
        is_i2c    = 1'b1;
        last_step = 3'd4;
        case (state)
            S_CONFIG:       last_step = 3'd5;
            S_POLL, S_READ: last_step = 3'd4;
            S_SET_PTR:      last_step = 3'd3;
            default: begin
                is_i2c    = 1'b0;
                last_step = 3'd0;
            end
        endcase
    end

    assign byte_done      = is_i2c && (hs == HS_WAIT_HIGH) && i2c_complete_i;
    assign frame_done     = is_i2c && (hs == HS_GAP) && (step == last_step);
    assign poll_exhausted = ({1'b0, poll_count} + 9'd1) >= {1'b0, MAX_POLLS};
    assign i2c_enable_o   = is_i2c && (hs != HS_GAP);
    assign busy_o         = (state != S_IDLE);

    always_comb begin
        i2c_instruction_o  = INSTR_START;
        i2c_byte_to_send_o = 8'h00;
        if (is_i2c) begin
            if (step == 3'd0) begin
                i2c_instruction_o = INSTR_START;
            end else if (step == last_step) begin
                i2c_instruction_o = INSTR_STOP;
            end else begin
                case (state)
                    S_CONFIG: begin
                        i2c_instruction_o = INSTR_WRITE;
                        case (step)
                            3'd1:    i2c_byte_to_send_o = {ADDRESS, 1'b0};
                            3'd2:    i2c_byte_to_send_o = 8'h01;
                            3'd3:    i2c_byte_to_send_o = {1'b1, mux_code, PGA, 1'b1};
                            default: i2c_byte_to_send_o = {DATA_RATE, 5'b00011};
                        endcase
                    end
                    S_SET_PTR: begin
                        i2c_instruction_o  = INSTR_WRITE;
                        i2c_byte_to_send_o = (step == 3'd1) ? {ADDRESS, 1'b0} : 8'h00;
                    end
                    default: begin
                        if (step == 3'd1) begin
                            i2c_instruction_o  = INSTR_WRITE;
                            i2c_byte_to_send_o = {ADDRESS, 1'b1};
                        end else begin
                            i2c_instruction_o = INSTR_READ;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start_i) state_next = S_CONFIG;
            S_CONFIG:  if (frame_done) state_next = S_DELAY;
            S_DELAY:   if (delay_cnt == POLL_DELAY) state_next = S_POLL;
            S_POLL: begin
                if (frame_done) begin
                    if (ready)               state_next = S_SET_PTR;
                    else if (poll_exhausted) state_next = S_NEXT;
                    else                     state_next = S_DELAY;
                end
            end
            S_SET_PTR: if (frame_done) state_next = S_READ;
            S_READ:    if (frame_done) state_next = S_PUBLISH;
            S_PUBLISH: state_next = S_NEXT;
            S_NEXT: begin
                if (ch < LAST_CH)       state_next = S_CONFIG;
                else if (continuous_i)  state_next = S_CONFIG;
                else                    state_next = S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_next;
    end

    // Completion must be seen low then high, so a stale high never ends a byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step <= 3'd0;
            hs   <= HS_WAIT_LOW;
        end else if (state_next != state) begin
            step <= 3'd0;
            hs   <= HS_WAIT_LOW;
        end else if (is_i2c) begin
            case (hs)
                HS_WAIT_LOW:  if (!i2c_complete_i) hs <= HS_WAIT_HIGH;
                HS_WAIT_HIGH: if (i2c_complete_i) hs <= HS_GAP;
                HS_GAP: begin
                    step <= step + 3'd1;
                    hs   <= HS_WAIT_LOW;
                end
                default:      hs <= HS_WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            delay_cnt        <= 8'd0;
            poll_count       <= 8'd0;
            ch               <= 2'd0;
            ready            <= 1'b0;
            rd_data          <= 16'h0000;
            timeout_o        <= 1'b0;
            sample_valid_o   <= 1'b0;
            sample_channel_o <= 2'd0;
            sample_data_o    <= 16'h0000;
            scan_done_o      <= 1'b0;
        end else begin
            sample_valid_o <= 1'b0;
            scan_done_o    <= 1'b0;

            delay_cnt <= (state == S_DELAY) ? delay_cnt + 8'd1 : 8'd0;

            if (state_next == S_CONFIG && state != S_CONFIG)
                poll_count <= 8'd0;
            else if (state == S_POLL && state_next != S_POLL && !ready)
                poll_count <= poll_count + 8'd1;

            if (byte_done && state == S_POLL && step == 3'd2)
                ready <= i2c_byte_received_i[7];
            if (byte_done && state == S_READ && step == 3'd2)
                rd_data[15:8] <= i2c_byte_received_i;
            if (byte_done && state == S_READ && step == 3'd3)
                rd_data[7:0] <= i2c_byte_received_i;

            if (state == S_IDLE && start_i)
                timeout_o <= 1'b0;
            else if (state == S_POLL && state_next == S_NEXT)
                timeout_o <= 1'b1;

            if (state == S_IDLE && start_i)
                ch <= 2'd0;
            else if (state == S_NEXT)
                ch <= (ch < LAST_CH) ? ch + 2'd1 : 2'd0;

            if (state == S_PUBLISH) begin
                sample_valid_o   <= 1'b1;
                sample_channel_o <= ch;
                sample_data_o    <= rd_data;
            end

            if (state == S_NEXT && ch == LAST_CH)
                scan_done_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_scanner.sv
// Bench for adc_scanner: behavioural I2C master plus ADS1115-style converter model,
// table-driven scan scenarios and a sample scoreboard.
module tb_adc_scanner;

    localparam int MAXP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        busy, valid, done, tout, en, complete;
    logic [1:0]  ch_o, instr;
    logic [15:0] data;
    logic [7:0]  tx, rx;

    always #5 clk = ~clk;

    adc_scanner dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start),
        .continuous_i       (continuous),
        .busy_o             (busy),
        .sample_valid_o     (valid),
        .sample_channel_o   (ch_o),
        .sample_data_o      (data),
        .scan_done_o        (done),
        .timeout_o          (tout),
        .i2c_instruction_o  (instr),
        .i2c_enable_o       (en),
        .i2c_byte_to_send_o (tx),
        .i2c_byte_received_i(rx),
        .i2c_complete_i     (complete)
    );

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // converter model state
    int          pos, rd_idx, pointer, cur_ch, not_ready, never_ch;
    bit          frame_read, frame_poll;
    int          frame_start, last_poll_stop, min_gap;
    int          poll_frames[4];
    logic [7:0]  cfg_hi, cfg_lo;
    logic [7:0]  cfg3_cap[4];
    logic [7:0]  cfg4_cap[4];
    int          instr_count = 0;
    int          proto_err = 0;

    logic [17:0] exp_q[$];
    logic [17:0] mon_exp;
    int          valid_count = 0;
    int          done_count = 0;
    logic        busy_at_done = 1'b0;

    typedef struct {
        int         not_ready;
        int         never_ch;
        int         cfg_ch;
        logic [7:0] exp_cfg3;
        logic [7:0] exp_cfg4;
        logic       exp_timeout;
        int         exp_polls_ch0;
    } vec_t;

    vec_t vecs[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelAction(input logic [1:0] op, input logic [7:0] b);
        logic [15:0] dval;
        case (op)
            2'd0: begin
                pos = 0; rd_idx = 0; frame_read = 0; frame_poll = 0; frame_start = cycle;
            end
            2'd3: begin
                if (pos == 0) begin
                    frame_read = b[0];
                    if (b[7:1] != 7'h48) proto_err++;
                    if (b[0] && pointer == 1) begin
                        frame_poll = 1;
                        if (poll_frames[cur_ch] > 0 && (frame_start - last_poll_stop) < min_gap)
                            min_gap = frame_start - last_poll_stop;
                        poll_frames[cur_ch]++;
                    end
                end else if (pos == 1) pointer = int'(b[1:0]);
                else if (pos == 2) cfg_hi = b;
                else if (pos == 3) cfg_lo = b;
                pos++;
            end
            2'd2: begin
                if (pointer == 1) begin
                    if (rd_idx == 0)
                        rx = (cur_ch != never_ch && poll_frames[cur_ch] > not_ready) ? 8'h85 : 8'h05;
                    else
                        rx = 8'h83;
                end else begin
                    dval = 16'h1234 + 16'(cur_ch);
                    rx = (rd_idx == 0) ? dval[15:8] : dval[7:0];
                end
                rd_idx++;
            end
            default: begin
                if (!frame_read && pos == 4) begin
                    cur_ch = int'(cfg_hi[6:4]) - 4;
                    if (cur_ch < 0 || cur_ch > 3) begin
                        proto_err++;
                        cur_ch = 0;
                    end
                    cfg3_cap[cur_ch] = cfg_hi;
                    cfg4_cap[cur_ch] = cfg_lo;
                    poll_frames[cur_ch] = 0;
                end
                if (frame_poll) last_poll_stop = cycle;
            end
        endcase
    endtask

    // I2C master: complete stays high from the last op for a cycle after enable rises
    logic [1:0] m_op;
    logic [7:0] m_b;
    int         m_wait;
    initial begin
        complete = 1'b1;
        rx = 8'h00;
        pointer = 0; cur_ch = 0; never_ch = -1; not_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (en) begin
                m_op = instr;
                m_b = tx;
                instr_count++;
                @(posedge clk); #1;
                complete = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                modelAction(m_op, m_b);
                complete = 1'b1;
                m_wait = 0;
                while (en && m_wait < 1000) begin
                    @(posedge clk); #1;
                    m_wait++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                valid_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_sample: got ch %0d data %0h, expected no sample", ch_o, data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("sample_channel", 32'(ch_o), 32'(mon_exp[17:16]));
                    checkOutput("sample_data", 32'(data), 32'(mon_exp[15:0]));
                end
            end
            if (done) begin
                done_count++;
                busy_at_done = busy;
            end
        end
    end

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pushScan(input int skip_ch);
        for (int c = 0; c < 4; c++)
            if (c != skip_ch) exp_q.push_back({2'(c), 16'h1234 + 16'(c)});
    endtask

    task automatic waitScans(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_count < target) begin
            errors++;
            $display("[TB] FAIL scan_wait: got %0d scan_done pulses, expected %0d", done_count, target);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        not_ready = v.not_ready;
        never_ch = v.never_ch;
        min_gap = 1000000;
        for (int c = 0; c < 4; c++) begin
            poll_frames[c] = 0;
            cfg3_cap[c] = 8'h00;
            cfg4_cap[c] = 8'h00;
        end
        pushScan(v.never_ch);
        pulseStart();
        repeat (100) @(negedge clk);
        pulseStart();
    endtask

    initial begin
        int v0, d0, n;

        vecs[0] = '{0, -1, 2, 8'hE3, 8'hE3, 1'b0, 1};
        vecs[1] = '{3, -1, 0, 8'hC3, 8'hE3, 1'b0, 4};
        vecs[2] = '{0,  1, 3, 8'hF3, 8'hE3, 1'b1, 1};
        vecs[3] = '{1, -1, 1, 8'hD3, 8'hE3, 1'b0, 2};

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_valid", 32'(valid), 0);
        checkOutput("rst_channel", 32'(ch_o), 0);
        checkOutput("rst_data", 32'(data), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_timeout", 32'(tout), 0);
        checkOutput("rst_enable", 32'(en), 0);
        checkOutput("rst_instr", 32'(instr), 0);
        checkOutput("rst_byte", 32'(tx), 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("no_instr_before_start", 32'(instr_count), 0);
        checkOutput("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 4; i++) begin
            $display("[TB] scan vector %0d", i);
            v0 = valid_count;
            d0 = done_count;
            applyStimulus(vecs[i]);
            waitScans(d0 + 1, 20000);
            repeat (5) @(negedge clk);
            checkOutput("end_busy", 32'(busy), 0);
            checkOutput("timeout_flag", 32'(tout), 32'(vecs[i].exp_timeout));
            checkOutput("valid_count", 32'(valid_count - v0), (vecs[i].never_ch >= 0) ? 32'd3 : 32'd4);
            checkOutput("scan_done_count", 32'(done_count - d0), 1);
            checkOutput("scoreboard_left", 32'(exp_q.size()), 0);
            checkOutput("cfg_byte3", 32'(cfg3_cap[vecs[i].cfg_ch]), 32'(vecs[i].exp_cfg3));
            checkOutput("cfg_byte4", 32'(cfg4_cap[vecs[i].cfg_ch]), 32'(vecs[i].exp_cfg4));
            checkOutput("poll_frames_ch0", 32'(poll_frames[0]), 32'(vecs[i].exp_polls_ch0));
            if (vecs[i].never_ch >= 0)
                checkOutput("poll_frames_timeout", 32'(poll_frames[vecs[i].never_ch]), MAXP);
            if (vecs[i].not_ready > 0)
                checkOutput("poll_gap_ge_256", 32'(min_gap >= 256), 1);
            exp_q.delete();
        end

        $display("[TB] continuous mode");
        not_ready = 0;
        never_ch = -1;
        v0 = valid_count;
        d0 = done_count;
        continuous = 1'b1;
        pushScan(-1);
        pushScan(-1);
        pulseStart();
        waitScans(d0 + 1, 20000);
        continuous = 1'b0;
        checkOutput("busy_held_at_done", 32'(busy_at_done), 1);
        waitScans(d0 + 2, 20000);
        repeat (5) @(negedge clk);
        checkOutput("cont_busy_end", 32'(busy), 0);
        checkOutput("cont_valid_count", 32'(valid_count - v0), 8);
        checkOutput("cont_done_count", 32'(done_count - d0), 2);
        checkOutput("cont_scoreboard_left", 32'(exp_q.size()), 0);
        exp_q.delete();

        $display("[TB] reset during data read");
        pulseStart();
        n = 0;
        while (!(en && instr == 2'd2 && pointer == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_data_read", 32'(n < 5000), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_enable", 32'(en), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_instr", 32'(instr), 0);
        checkOutput("midrst_byte", 32'(tx), 0);
        checkOutput("midrst_valid", 32'(valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        v0 = valid_count;
        d0 = done_count;
        pushScan(-1);
        pulseStart();
        waitScans(d0 + 1, 20000);
        repeat (5) @(negedge clk);
        checkOutput("post_rst_valid_count", 32'(valid_count - v0), 4);
        checkOutput("post_rst_scoreboard_left", 32'(exp_q.size()), 0);
        checkOutput("post_rst_busy", 32'(busy), 0);
        checkOutput("post_rst_timeout", 32'(tout), 0);
        checkOutput("protocol_errors", 32'(proto_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
